// File: rtl/glitch_pkg.sv
// glitch_pkg: shared state encoding and config register map for the glitch sequencer.
package glitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_PULSE   = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Register map: width/gap pairs are interleaved after holdoff and ctrl.
    localparam int REG_HOLDOFF = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_W_BASE  = 2;
    localparam int REG_G_BASE  = 3;

    // Ctrl register fields: [0] idle polarity, [CTR_WIDTH-1:1] pulse count minus one.
    localparam int CTRL_POL_BIT = 0;
    localparam int CTRL_NP_LSB  = 1;

endpackage

// File: rtl/glitch_pulse_table.sv
// glitch_pulse_table: config register file (holdoff, ctrl, per-pulse width/gap).
// Writes land only while the sequencer is idle; refused writes raise a one-cycle
// reject flag on the cycle after the write strobe.
module glitch_pulse_table
    import glitch_pkg::*;
#(
    parameter int CTR_WIDTH  = 32,
    parameter int NUM_PULSES = 4,
    parameter int ADDR_W     = 4,
    parameter int IDX_W      = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [CTR_WIDTH-1:0] i_wdata,
    input  logic                 i_open,
    output logic                 o_rej,
    output logic [CTR_WIDTH-1:0] o_holdoff,
    output logic                 o_polarity,
    output logic [IDX_W-1:0]     o_npm1,
    input  logic [IDX_W-1:0]     i_w_idx,
    output logic [CTR_WIDTH-1:0] o_width,
    input  logic [IDX_W-1:0]     i_g_idx,
    output logic [CTR_WIDTH-1:0] o_gap
);

    localparam int NUM_REGS = 2 + 2 * NUM_PULSES;

    logic [CTR_WIDTH-1:0] r_holdoff;
    logic                 r_polarity;
    logic [IDX_W-1:0]     r_npm1;
    logic [CTR_WIDTH-1:0] r_width [NUM_PULSES];
    logic [CTR_WIDTH-1:0] r_gap   [NUM_PULSES];
    logic                 r_rej;

    logic                 w_in_range;
    logic                 w_wr;
    logic [CTR_WIDTH-2:0] w_np_field;
    logic [IDX_W-1:0]     w_np_sat;

    assign w_in_range = (32'(i_addr) < 32'(NUM_REGS));
    assign w_wr       = i_we & i_open & w_in_range;
    assign w_np_field = i_wdata[CTR_WIDTH-1:CTRL_NP_LSB];
    // A pulse count larger than the table clamps to the last table entry.
    assign w_np_sat   = (w_np_field > (CTR_WIDTH-1)'(NUM_PULSES - 1)) ?
                        IDX_W'(NUM_PULSES - 1) : w_np_field[IDX_W-1:0];

    // Config storage, written only while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_holdoff  <= '0;
            r_polarity <= 1'b0;
            r_npm1     <= '0;
            for (int i = 0; i < NUM_PULSES; i++) begin
                r_width[i] <= '0;
                r_gap[i]   <= '0;
            end
        end else if (w_wr) begin
            if (i_addr == ADDR_W'(REG_HOLDOFF)) begin
                r_holdoff <= i_wdata;
            end else if (i_addr == ADDR_W'(REG_CTRL)) begin
                r_polarity <= i_wdata[CTRL_POL_BIT];
                r_npm1     <= w_np_sat;
            end else begin
                for (int i = 0; i < NUM_PULSES; i++) begin
                    if (i_addr == ADDR_W'(REG_W_BASE + 2 * i)) r_width[i] <= i_wdata;
                    if (i_addr == ADDR_W'(REG_G_BASE + 2 * i)) r_gap[i]   <= i_wdata;
                end
            end
        end
    end

    // Reject flag: busy sequencer or address past the end of the map.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rej <= 1'b0;
        else       r_rej <= i_we & (~i_open | ~w_in_range);
    end

    assign o_rej      = r_rej;
    assign o_holdoff  = r_holdoff;
    assign o_polarity = r_polarity;
    assign o_npm1     = r_npm1;
    assign o_width    = r_width[i_w_idx];
    assign o_gap      = r_gap[i_g_idx];

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: multi-pulse glitch generator. After arm and a trigger edge it
// releases target reset, waits a holdoff, then emits up to NUM_PULSES pulses.
// Build macro TRIG_SYNC_EN: when defined, trig passes a 2-flop synchroniser
// (2 extra cycles of trigger latency); otherwise trig must be clk-synchronous.
//
//  state   | meaning
//  IDLE    | config writable, target held in reset, glitch at idle level
//  ARMED   | waiting for a trig 0->1 edge
//  HOLDOFF | target released, counting holdoff
//  PULSE   | glitch active for width of current pulse
//  GAP     | glitch idle between pulses
//  DONE    | shot complete, target stays released, re-arm allowed
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter  int CTR_WIDTH  = 32,
    parameter  int NUM_PULSES = 4,
    localparam int ADDR_W     = $clog2(2 + 2 * NUM_PULSES),
    localparam int IDX_W      = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_we,
    input  logic [ADDR_W-1:0]    i_cfg_addr,
    input  logic [CTR_WIDTH-1:0] i_cfg_wdata,
    output logic                 o_cfg_rej,
    input  logic                 i_arm,
    input  logic                 i_abort,
    input  logic                 i_trig,
    output logic                 o_glitch,
    output logic                 o_target_release,
    output logic                 o_armed,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [IDX_W-1:0]     o_pulse_idx
);

    state_t               r_state, w_next;
    logic [CTR_WIDTH-1:0] r_ctr;
    logic [IDX_W-1:0]     r_pulse_idx;
    logic                 r_trig_q;
    logic                 w_trig_s, w_trig_edge;
    logic                 w_ctr_zero, w_last;
    logic [IDX_W-1:0]     w_w_idx, w_npm1;
    logic [CTR_WIDTH-1:0] w_holdoff, w_width, w_gap;
    logic                 w_polarity;

`ifdef TRIG_SYNC_EN
    logic r_trig_s1, r_trig_s2;

    // Two-flop synchroniser for an asynchronous trigger source.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
        end else begin
            r_trig_s1 <= i_trig;
            r_trig_s2 <= r_trig_s1;
        end
    end
    assign w_trig_s = r_trig_s2;
`else
    assign w_trig_s = i_trig;
`endif

    // Trigger history updates in every state so a level held across arm never fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_trig_q <= 1'b0;
        else       r_trig_q <= w_trig_s;
    end

    assign w_trig_edge = w_trig_s & ~r_trig_q;
    assign w_ctr_zero  = (r_ctr == '0);
    assign w_last      = (r_pulse_idx == w_npm1);
    // Width lookup points at the upcoming pulse: W_0 from holdoff, W_(i+1) from a gap.
    assign w_w_idx     = (r_state == ST_GAP) ? r_pulse_idx + 1'b1 : '0;

    glitch_pulse_table #(
        .CTR_WIDTH  (CTR_WIDTH),
        .NUM_PULSES (NUM_PULSES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W)
    ) u_table (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (i_cfg_we),
        .i_addr     (i_cfg_addr),
        .i_wdata    (i_cfg_wdata),
        .i_open     (r_state == ST_IDLE),
        .o_rej      (o_cfg_rej),
        .o_holdoff  (w_holdoff),
        .o_polarity (w_polarity),
        .o_npm1     (w_npm1),
        .i_w_idx    (w_w_idx),
        .o_width    (w_width),
        .i_g_idx    (r_pulse_idx),
        .o_gap      (w_gap)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; abort outranks everything but reset.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (i_arm)       w_next = ST_ARMED;
                ST_ARMED:   if (w_trig_edge) w_next = ST_HOLDOFF;
                ST_HOLDOFF: if (w_ctr_zero)  w_next = ST_PULSE;
                ST_PULSE:   if (w_ctr_zero)  w_next = w_last ? ST_DONE : ST_GAP;
                ST_GAP:     if (w_ctr_zero)  w_next = ST_PULSE;
                ST_DONE:    if (i_arm)       w_next = ST_ARMED;
                default:                     w_next = ST_IDLE;
            endcase
        end
    end

    // Down-counter: loaded on entry to a timed state, then counts to zero and holds.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ctr <= '0;
        else if (w_next != r_state && w_next == ST_HOLDOFF)
            r_ctr <= w_holdoff;
        else if (w_next != r_state && w_next == ST_PULSE)
            r_ctr <= w_width;
        else if (w_next != r_state && w_next == ST_GAP)
            r_ctr <= w_gap;
        else if (!w_ctr_zero)
            r_ctr <= r_ctr - 1'b1;
    end

    // Pulse index restarts at the first pulse and advances at each gap->pulse step.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_pulse_idx <= '0;
        else if (r_state == ST_HOLDOFF && w_next == ST_PULSE)
            r_pulse_idx <= '0;
        else if (r_state == ST_GAP && w_next == ST_PULSE)
            r_pulse_idx <= w_w_idx;
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        o_glitch         = w_polarity;
        o_target_release = 1'b0;
        o_armed          = 1'b0;
        o_busy           = 1'b0;
        o_done           = 1'b0;
        case (r_state)
            ST_ARMED: o_armed = 1'b1;
            ST_HOLDOFF, ST_GAP: begin
                o_busy           = 1'b1;
                o_target_release = 1'b1;
            end
            ST_PULSE: begin
                o_busy           = 1'b1;
                o_target_release = 1'b1;
                o_glitch         = ~w_polarity;
            end
            ST_DONE: begin
                o_done           = 1'b1;
                o_target_release = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_pulse_idx = r_pulse_idx;

endmodule
